// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronizes an async reset, stretches it, then releases
// NUM_CH reset channels one by one in index order, with a software restart.
// Ports:
//   CLK        - rising-edge clock
//   RST        - asynchronous active-high reset
//   SW_RST_REQ - synchronous software reset request
//   SYNC_RST   - per-channel active-high reset, bit 0 released first
//   RST_DONE   - high once every channel is released
//   RST_CAUSE  - source of last reset (0 = RST, 1 = SW_RST_REQ)
module reset_sequencer #(
  parameter int NUM_STAGES  = 2,
  parameter int NUM_CH      = 4,
  parameter int STRETCH_CYC = 16,
  parameter int STAGGER_CYC = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SW_RST_REQ,
  output logic [NUM_CH-1:0] SYNC_RST,
  output logic              RST_DONE,
  output logic              RST_CAUSE
);

  localparam int MAXC = (STRETCH_CYC > STAGGER_CYC) ?
                        STRETCH_CYC : STAGGER_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = $clog2(NUM_CH) + 1;

  // Software restart counts the full stretch from the request edge.
  localparam logic [CW-1:0] S_M1 = CW'(STRETCH_CYC - 1);
  // Leaving SYNC already consumes one stretch cycle (the edge that
  // sees the chain output high), so load one less.
  localparam logic [CW-1:0] S_M2 =
    CW'((STRETCH_CYC > 1) ? STRETCH_CYC - 2 : 0);
  localparam logic [CW-1:0] T_M1 = CW'(STAGGER_CYC - 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_CH - 1);

  typedef enum logic [1:0] {
    SYNC,
    STRETCH,
    RELEASE,
    RUN
  } state_e;

  state_e            state_q, state_d;
  logic [NUM_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [NUM_CH-1:0] rst_q, rst_d;
  logic              done_q, done_d;
  logic              cause_q, cause_d;
  logic              sw_hit;
  logic              rel_en;
  logic [IW-1:0]     rel_idx;
  logic              sync_out;

  assign sync_d   = {sync_q[NUM_STAGES-2:0], 1'b1};
  assign sync_out = sync_q[NUM_STAGES-1];

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, counter and channel index
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sw_hit  = 1'b0;
    rel_en  = 1'b0;
    rel_idx = '0;
    unique case (state_q)
      SYNC: begin
        if (sync_out) begin
          if (STRETCH_CYC == 1) begin
            rel_en  = 1'b1;
            state_d = (NUM_CH == 1) ? RUN : RELEASE;
            cnt_d   = T_M1;
            idx_d   = IW'(1);
          end else begin
            state_d = STRETCH;
            cnt_d   = S_M2;
          end
        end
      end
      STRETCH: begin
        if (cnt_q == '0) begin
          rel_en  = 1'b1;
          state_d = (NUM_CH == 1) ? RUN : RELEASE;
          cnt_d   = T_M1;
          idx_d   = IW'(1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RELEASE: begin
        if (cnt_q == '0) begin
          rel_en  = 1'b1;
          rel_idx = idx_q;
          cnt_d   = T_M1;
          if (idx_q == LAST) begin
            state_d = RUN;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RUN: begin
        state_d = RUN;
      end
    endcase
    // Software request wins over any release on the same edge.
    if (SW_RST_REQ && (state_q != SYNC)) begin
      sw_hit  = 1'b1;
      rel_en  = 1'b0;
      state_d = STRETCH;
      cnt_d   = S_M1;
      idx_d   = '0;
    end
  end

  // Output flop next values
  always_comb begin
    rst_d   = rst_q;
    done_d  = done_q;
    cause_d = cause_q;
    if (sw_hit) begin
      rst_d   = '1;
      done_d  = 1'b0;
      cause_d = 1'b1;
    end else if (rel_en) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (rel_idx == IW'(k)) begin
          rst_d[k] = 1'b0;
        end
      end
      if (rel_idx == LAST) begin
        done_d = 1'b1;
      end
    end
  end

  // Datapath and output flops
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      done_q  <= 1'b0;
      cause_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
      cause_q <= cause_d;
    end
  end

  assign SYNC_RST  = rst_q;
  assign RST_DONE  = done_q;
  assign RST_CAUSE = cause_q;

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter NUM_STAGES, default 2: synchronizer depth in flops; legal range 2..8.
REQ-002 Parameter NUM_CH, default 4: number of reset output channels; legal range 1..8.
REQ-003 Parameter STRETCH_CYC, default 16: cycles between synchronizer release and channel 0 release; legal range >=1.
REQ-004 Parameter STAGGER_CYC, default 4: cycles between consecutive channel releases; legal range >=1.
REQ-005 Port CLK, input, 1: single clock; all logic is rising-edge.
REQ-006 Port RST, input, 1: asynchronous, active-high reset.
REQ-007 Port SW_RST_REQ, input, 1: synchronous software reset request, sampled on CLK.
REQ-008 Port SYNC_RST, output, NUM_CH: per-channel active-high reset; bit 0 is released first.
REQ-009 Port RST_DONE, output, 1: high when all channels are released.
REQ-010 Port RST_CAUSE, output, 1: source of the last reset, 0 = RST and 1 = SW_RST_REQ.

Function
REQ-011 The block SHALL contain a NUM_STAGES-deep synchronizer chain with D of the first flop tied to 1, all chain flops cleared asynchronously by RST, and the chain output gating the sequencer.
REQ-012 The FSM SHALL have states SYNC, STRETCH, RELEASE and RUN, with SYNC as the reset state.
REQ-013 Transition SYNC->STRETCH: when the chain output is high.
REQ-014 Transition STRETCH->RELEASE: when the stretch count expires.
REQ-015 Transition RELEASE->RUN: when the last channel is released.
REQ-016 Transition RUN stays in RUN until RST or SW_RST_REQ.
REQ-017 Timing, numbering E1 as the first rising edge after RST falls: SYNC_RST[0] SHALL go low after edge E(NUM_STAGES+STRETCH_CYC).
REQ-018 SYNC_RST[k] SHALL go low after edge E(NUM_STAGES+STRETCH_CYC+k*STAGGER_CYC).
REQ-019 RST_DONE SHALL rise on the same edge as the release of SYNC_RST[NUM_CH-1].
REQ-020 Once released, a channel SHALL stay low until the next RST or software reset; channels SHALL never release out of index order.
REQ-021 SW_RST_REQ sampled high at edge Es in STRETCH, RELEASE or RUN SHALL, after Es, set all SYNC_RST bits to 1, RST_DONE to 0 and RST_CAUSE to 1, and put the FSM in STRETCH with the counter restarted.
REQ-022 After a software reset, SYNC_RST[k] SHALL go low after edge Es+STRETCH_CYC+k*STAGGER_CYC.
REQ-023 SW_RST_REQ held high SHALL restart the stretch count on every sampled-high edge, so the release timing is measured from the last high sample.
REQ-024 SW_RST_REQ SHALL be ignored in SYNC.
REQ-025 A single cycle counter SHALL be sized $clog2(max(STRETCH_CYC, STAGGER_CYC)+1) bits and reloaded at each phase boundary.
REQ-026 A channel index register of $clog2(NUM_CH)+1 bits SHALL be used; no counter SHALL wrap during normal operation.
REQ-027 With NUM_CH=1, the FSM SHALL go STRETCH->RUN directly, with SYNC_RST[0] release and RST_DONE rise on the same edge.
REQ-028 All outputs SHALL be driven directly from flops, with no combinational paths from inputs to outputs.

Reset
REQ-029 RST high SHALL asynchronously, with no clock required, force SYNC_RST to all 1s, RST_DONE to 0, RST_CAUSE to 0, the FSM to SYNC, and all counters and chain flops to 0.
REQ-030 RST asserted mid-sequence (STRETCH, RELEASE or RUN) SHALL abort immediately; the full sequence SHALL restart from E1 after RST falls.
REQ-031 RST asserted together with SW_RST_REQ SHALL give the RST behaviour, with RST_CAUSE=0.
REQ-032 Deassertion of RST SHALL affect outputs only through the synchronizer, never asynchronously.

Verification
REQ-033 Defaults, RST pulse then release -> SYNC_RST = 4'b1111 until E18; after E18 = 4'b1110; after E22 = 4'b1100; after E26 = 4'b1000; after E30 = 4'b0000, with RST_DONE=1 and RST_CAUSE=0.
REQ-034 In RUN, a 1-cycle SW_RST_REQ at Es -> SYNC_RST=4'b1111 after Es; bit 0 low after Es+16 and bit 3 low after Es+28; RST_CAUSE=1 and RST_DONE=1 after Es+28.
REQ-035 SW_RST_REQ high for 5 cycles ending at edge Es+4 -> bit 0 releases after Es+20; no channel releases early.
REQ-036 RST asserted between clock edges while SYNC_RST=4'b1100 -> outputs go 4'b1111 with RST_DONE=0 before the next edge; the sequence restarts with full timing after release.
REQ-037 NUM_STAGES=3, NUM_CH=1, STRETCH_CYC=1 -> SYNC_RST[0] and RST_DONE change on edge E4; SW_RST_REQ during SYNC has no effect.
REQ-038 Assertions checked throughout every test: channels release in monotonic index order; RST_DONE == ~|SYNC_RST.
